iomem_timer: RTL and testbench
==============================

# iomem_timer

Programmable 32-bit down-counting timer on the SoC's `iomem_*` bus, downstream of the SoC top's external memory port. Its interrupt output drives the SoC's `irq_5` input. Firmware loads a count and a prescaler, then receives a one-shot or periodic interrupt on expiry. An optional PWM compare output is provided for board-level use.

## Interface
Parameters:
- `BASE_ADDR`, default 32'h0300_0000 — base of the 256-byte register window; decode is `iomem_addr[31:8] == BASE_ADDR[31:8]`.

Ports:
- `clk` in 1 — single clock for the whole block.
- `reset` in 1 — asynchronous, active-high reset.
- `iomem_valid` in 1 — bus request; held by the master until `iomem_ready`.
- `iomem_ready` out 1 — one-cycle acknowledge.
- `iomem_wstrb` in 4 — byte write strobes; 0 means read.
- `iomem_addr` in 32 — byte address.
- `iomem_wdata` in 32 — write data.
- `iomem_rdata` out 32 — read data; valid while `iomem_ready` is high, otherwise 0.
- `irq` out 1 — level interrupt, equal to `STATUS.expired & CTRL.irq_en`.
- `pwm_out` out 1 — PWM output; present only with `IOMEM_TIMER_PWM_EN`.

## Operation
Register map (offset = `iomem_addr[7:0]`, word-aligned; all writes honour `iomem_wstrb` per byte):
- 0x00 `CTRL`: bit0 = enable, bit1 = auto_reload, bit2 = irq_en. Other bits read 0.
- 0x04 `LOAD`: 32-bit reload value.
- 0x08 `COUNT`: reads the live count; a write sets the count directly.
- 0x0C `PRESCALE`: bits[15:0] = P. Upper bits read 0.
- 0x10 `STATUS`: bit0 = expired. Writing 1 clears it; writing 0 has no effect.
- 0x14 `CMP`: PWM compare value (PWM build only; otherwise reads 0 and writes are ignored).
- Other in-window offsets: acknowledged; read 0; writes ignored.
- Out-of-window addresses: never acknowledged. `iomem_rdata` stays 0.

Counting:
- A prescaler counter `pc` (16 bits) runs only while enable is set.
- Tick = enable && `pc == P`. On a tick, `pc` returns to 0; otherwise it increments. A tick therefore occurs every P+1 cycles.
- `pc` clears whenever enable is 0, and on any write to `PRESCALE`.
- On a tick with `COUNT != 0`: `COUNT` decrements by 1.
- On a tick with `COUNT == 0`: expired is set.
  - If auto_reload is set, `COUNT` takes the value of `LOAD`.
  - Otherwise `COUNT` stays at 0 and enable clears.
- With auto_reload and `LOAD = N`, expiry recurs every (N+1)·(P+1) cycles.

Collisions (resolved at the same clock edge):
- A bus write to `COUNT` beats the tick's decrement or reload.
- A bus write to `CTRL` beats the hardware clear of enable.
- Hardware set of expired beats a W1C clear of expired.

## Timing
- Reset values: `iomem_ready` 0, `iomem_rdata` 0, `irq` 0, `pwm_out` 0. All registers and `pc` reset to 0.
- Handshake: `iomem_ready <= iomem_valid && hit && !iomem_ready`.
  - `iomem_ready` rises the cycle after `valid` and the address hit are first sampled, and stays high for exactly 1 cycle.
  - Back-to-back requests are served at most one every 2 cycles.
- Reads: `iomem_rdata` is registered. It shows the register value sampled on the edge that raises `iomem_ready`, and returns to 0 the following cycle.
- Writes: committed on the same edge that raises `iomem_ready`, so they are visible to a read issued on the next request.
- `irq` is combinational from registered state. It rises the cycle after the expiring tick edge, and falls the cycle after the W1C write commits.
- If reset asserts mid-transaction, `iomem_ready` drops immediately and the transaction is lost. The master must reissue it.

## Configuration
- `IOMEM_TIMER_PWM_EN` defined:
  - The `CMP` register and `pwm_out` port exist.
  - `pwm_out` is registered: `pwm_out <= enable && (COUNT < CMP)`.
- `IOMEM_TIMER_PWM_EN` undefined:
  - No `pwm_out` port and no `CMP` storage.
  - Offset 0x14 behaves as an unmapped in-window offset.

## Test plan
- Reset, then read all registers at `BASE_ADDR` + 0x00..0x14 → all return 0. Each `iomem_ready` pulse is exactly 1 cycle, arriving 1 cycle after `valid`.
- One-shot: LOAD=COUNT=3, P=0, CTRL=0b101 → `irq` rises 4 cycles after enable commits; CTRL reads 0b100 and COUNT reads 0. Write STATUS=1 → `irq` falls the next cycle.
- Auto-reload: LOAD=COUNT=4, P=1, CTRL=0b111 → expired is set every 10 cycles. Clearing STATUS in the same cycle as an expiry leaves expired = 1.
- Byte strobes: write 0xAABBCCDD to LOAD with wstrb=0b0100 → LOAD reads 0x00BB0000. A write to `BASE_ADDR` + 0x40 is acknowledged and has no effect. Address 0x0400_0000 gets no `iomem_ready` within 10 cycles.
- Collision: a COUNT write of 100 lands on a tick edge where COUNT = 0 with auto_reload → COUNT reads 100, and expired is still set.
- PWM build: LOAD=COUNT=9, CMP=3, P=0, auto_reload → `pwm_out` is high 3 of every 10 cycles. Reset asserted mid-period drives `pwm_out` to 0 asynchronously.

Source files
------------

// File: rtl/iomem_timer.sv
`default_nettype none
// ============================================================================
// Module      : iomem_timer
// Description : 32-bit down-counting timer with 16-bit prescaler on the SoC
//               iomem bus. One-shot or auto-reload expiry raises a level irq.
//               Optional PWM compare output, enabled by the build macro
//               IOMEM_TIMER_PWM_EN (adds the CMP register and pwm_out).
// Revision    : 1.0 - initial release
// ============================================================================
module iomem_timer #(
  parameter logic [31:0] BASE_ADDR = 32'h0300_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        iomem_valid,
  output logic        iomem_ready,
  input  logic [3:0]  iomem_wstrb,
  input  logic [31:0] iomem_addr,
  input  logic [31:0] iomem_wdata,
  output logic [31:0] iomem_rdata,
`ifdef IOMEM_TIMER_PWM_EN
  output logic        pwm_out,
`endif
  output logic        irq
);

  localparam logic [7:0] OFF_CTRL     = 8'h00;
  localparam logic [7:0] OFF_LOAD     = 8'h04;
  localparam logic [7:0] OFF_COUNT    = 8'h08;
  localparam logic [7:0] OFF_PRESCALE = 8'h0C;
  localparam logic [7:0] OFF_STATUS   = 8'h10;
`ifdef IOMEM_TIMER_PWM_EN
  localparam logic [7:0] OFF_CMP      = 8'h14;
`endif

  logic        enable;
  logic        auto_reload;
  logic        irq_en;
  logic        expired;
  logic [31:0] load;
  logic [31:0] count;
  logic [15:0] prescale;
  logic [15:0] pc;
`ifdef IOMEM_TIMER_PWM_EN
  logic [31:0] cmp;
`endif

  logic        hit;
  logic        access;
  logic        wr;
  logic [7:0]  off;
  logic        tick;
  logic        count_zero;
  logic [31:0] rd_mux;

  // Replace only the bytes selected by the write strobes
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) res[8*i +: 8] = new_val[8*i +: 8];
    end
    return res;
  endfunction

  assign hit        = (iomem_addr[31:8] == BASE_ADDR[31:8]);
  // A request is taken on the edge that raises ready; the !ready term
  // forces at least one idle cycle between back-to-back requests.
  assign access     = iomem_valid && hit && !iomem_ready;
  assign wr         = access && (iomem_wstrb != 4'h0);
  assign off        = iomem_addr[7:0];
  assign tick       = enable && (pc == prescale);
  assign count_zero = (count == 32'h0);
  assign irq        = expired & irq_en;

  // Read-back multiplexer over the live register values
  always_comb begin
    rd_mux = 32'h0;
    case (off)
      OFF_CTRL:     rd_mux = {29'h0, irq_en, auto_reload, enable};
      OFF_LOAD:     rd_mux = load;
      OFF_COUNT:    rd_mux = count;
      OFF_PRESCALE: rd_mux = {16'h0, prescale};
      OFF_STATUS:   rd_mux = {31'h0, expired};
`ifdef IOMEM_TIMER_PWM_EN
      OFF_CMP:      rd_mux = cmp;
`endif
      default:      rd_mux = 32'h0;
    endcase
  end

  // Bus handshake: one-cycle ready pulse, registered read data (0 otherwise)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      iomem_ready <= 1'b0;
      iomem_rdata <= 32'h0;
    end else begin
      iomem_ready <= access;
      iomem_rdata <= (access && !wr) ? rd_mux : 32'h0;
    end
  end

  // Registers, prescaler and counter; later assignments encode collision
  // priority: bus writes beat tick updates, hardware expiry beats W1C.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      enable      <= 1'b0;
      auto_reload <= 1'b0;
      irq_en      <= 1'b0;
      expired     <= 1'b0;
      load        <= 32'h0;
      count       <= 32'h0;
      prescale    <= 16'h0;
      pc          <= 16'h0;
`ifdef IOMEM_TIMER_PWM_EN
      cmp         <= 32'h0;
      pwm_out     <= 1'b0;
`endif
    end else begin
      if (!enable || tick || (wr && off == OFF_PRESCALE)) pc <= 16'h0;
      else                                              pc <= pc + 16'd1;

      if (tick) begin
        if (!count_zero)      count  <= count - 32'd1;
        else if (auto_reload) count  <= load;
        else                  enable <= 1'b0;
      end

      if (wr) begin
        case (off)
          OFF_CTRL: begin
            if (iomem_wstrb[0]) begin
              enable      <= iomem_wdata[0];
              auto_reload <= iomem_wdata[1];
              irq_en      <= iomem_wdata[2];
            end
          end
          OFF_LOAD:  load  <= merge_bytes(load, iomem_wdata, iomem_wstrb);
          OFF_COUNT: count <= merge_bytes(count, iomem_wdata, iomem_wstrb);
          OFF_PRESCALE: begin
            if (iomem_wstrb[0]) prescale[7:0]  <= iomem_wdata[7:0];
            if (iomem_wstrb[1]) prescale[15:8] <= iomem_wdata[15:8];
          end
          OFF_STATUS: begin
            if (iomem_wstrb[0] && iomem_wdata[0]) expired <= 1'b0;
          end
`ifdef IOMEM_TIMER_PWM_EN
          OFF_CMP:   cmp   <= merge_bytes(cmp, iomem_wdata, iomem_wstrb);
`endif
          default: ;
        endcase
      end

      if (tick && count_zero) expired <= 1'b1;

`ifdef IOMEM_TIMER_PWM_EN
      pwm_out <= enable && (count < cmp);
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_iomem_timer.sv
`default_nettype none
// ============================================================================
// Module      : tb_iomem_timer
// Description : Self-checking bench for iomem_timer: directed scenarios plus
//               randomized bus traffic against a behavioural reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_iomem_timer;

  localparam logic [31:0] BASE = 32'h0300_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid;
  logic        ready;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;
`ifdef IOMEM_TIMER_PWM_EN
  logic        pwm;
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit chk_on = 1'b0;

  iomem_timer #(.BASE_ADDR(BASE)) dut (
    .clk         (clk),
    .reset       (reset),
    .iomem_valid (valid),
    .iomem_ready (ready),
    .iomem_wstrb (wstrb),
    .iomem_addr  (addr),
    .iomem_wdata (wdata),
    .iomem_rdata (rdata),
`ifdef IOMEM_TIMER_PWM_EN
    .pwm_out     (pwm),
`endif
    .irq         (irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_load, m_count, m_cmp, m_rdata, o_count;
  logic [15:0] m_p, m_pc;
  logic        m_en, m_ar, m_ie, m_exp, m_ready, m_pwm;
  logic        t_acc, t_wr, t_tick, t_expire;
  logic [7:0]  t_off;
  logic [31:0] t_rv;

  function automatic logic [31:0] bytes_in(input logic [31:0] old_v, input logic [31:0] new_v,
                                           input logic [3:0] s);
    logic [31:0] r;
    r = old_v;
    for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = new_v[8*i +: 8];
    return r;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_load = 0; m_count = 0; m_cmp = 0; m_p = 0; m_pc = 0;
      m_en = 0; m_ar = 0; m_ie = 0; m_exp = 0; m_ready = 0; m_rdata = 0; m_pwm = 0;
    end else begin
      t_acc    = valid && (addr[31:8] == BASE[31:8]) && !m_ready;
      t_wr     = t_acc && (wstrb != 4'h0);
      t_off    = addr[7:0];
      t_tick   = m_en && (m_pc == m_p);
      t_expire = t_tick && (m_count == 0);
      o_count  = m_count;
      case (t_off)
        8'h00:   t_rv = {29'd0, m_ie, m_ar, m_en};
        8'h04:   t_rv = m_load;
        8'h08:   t_rv = m_count;
        8'h0C:   t_rv = {16'd0, m_p};
        8'h10:   t_rv = {31'd0, m_exp};
`ifdef IOMEM_TIMER_PWM_EN
        8'h14:   t_rv = m_cmp;
`endif
        default: t_rv = 0;
      endcase
      m_rdata = (t_acc && !t_wr) ? t_rv : 32'h0;
      m_ready = t_acc;
      m_pwm   = m_en && (m_count < m_cmp);
      // prescaler: counts 0..P while enabled
      m_pc = (!m_en || t_tick) ? 16'd0 : m_pc + 16'd1;
      if (t_tick) begin
        if (m_count != 0) m_count = m_count - 1;
        else if (m_ar)    m_count = m_load;
        else              m_en = 0;
      end
      if (t_wr) begin
        case (t_off)
          8'h00: if (wstrb[0]) begin m_en = wdata[0]; m_ar = wdata[1]; m_ie = wdata[2]; end
          8'h04: m_load  = bytes_in(m_load, wdata, wstrb);
          8'h08: m_count = bytes_in(o_count, wdata, wstrb);
          8'h0C: begin m_p = 16'(bytes_in({16'd0, m_p}, wdata, wstrb & 4'b0011)); m_pc = 0; end
          8'h10: if (wstrb[0] && wdata[0]) m_exp = 0;
`ifdef IOMEM_TIMER_PWM_EN
          8'h14: m_cmp = bytes_in(m_cmp, wdata, wstrb);
`endif
          default: ;
        endcase
      end
      if (t_expire) m_exp = 1;
    end
  end

  // Cycle-by-cycle comparison of all outputs against the model
  always @(posedge clk) begin
    #1;
    if (chk_on) begin
      check_eq("ready", {31'd0, ready}, {31'd0, m_ready});
      check_eq("rdata", rdata, m_rdata);
      check_eq("irq", {31'd0, irq}, {31'd0, m_exp & m_ie});
`ifdef IOMEM_TIMER_PWM_EN
      check_eq("pwm", {31'd0, pwm}, {31'd0, m_pwm});
`endif
    end
  end

  // ---------------- bus helpers ----------------
  task automatic bus(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d,
                     output logic [31:0] q, output bit ok, output int lat);
    valid = 1'b1; addr = a; wstrb = s; wdata = d;
    ok = 1'b0; lat = 0; q = 32'h0;
    for (int i = 1; i <= 10 && !ok; i++) begin
      @(posedge clk); #1;
      if (ready) begin ok = 1'b1; lat = i; q = rdata; end
    end
    valid = 1'b0; wstrb = 4'h0;
  endtask

  task automatic reg_write(input logic [7:0] o, input logic [31:0] d, input logic [3:0] s = 4'hF);
    logic [31:0] q; bit ok; int lat;
    bus(BASE | {24'd0, o}, s, d, q, ok, lat);
    check_eq("wr_ack", {31'd0, ok}, 32'd1);
  endtask

  task automatic reg_read(input logic [7:0] o, output logic [31:0] q);
    bit ok; int lat;
    bus(BASE | {24'd0, o}, 4'h0, 32'h0, q, ok, lat);
    check_eq("rd_ack", {31'd0, ok}, 32'd1);
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_irq(output int t);
    int n;
    n = 0;
    while (!irq && n < 60) begin @(posedge clk); #1; n++; end
    t = cyc;
    if (!irq) check_eq("irq_timeout", {31'd0, irq}, 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] q, a, d;
    logic [3:0]  s;
    bit ok;
    int lat, c, t0, t1, n, sel;

    valid = 0; wstrb = 0; addr = 0; wdata = 0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_on = 1'b1;
    check_eq("rst_ready", {31'd0, ready}, 32'd0);
    check_eq("rst_rdata", rdata, 32'd0);
    check_eq("rst_irq", {31'd0, irq}, 32'd0);
`ifdef IOMEM_TIMER_PWM_EN
    check_eq("rst_pwm", {31'd0, pwm}, 32'd0);
`endif
    reset = 1'b0;

    // reset values of every register, one-cycle ack latency and width
    for (int o = 0; o <= 20; o += 4) begin
      bus(BASE + 32'(o), 4'h0, 32'h0, q, ok, lat);
      check_eq("rst_read", q, 32'd0);
      check_eq("ack_latency", 32'(lat), 32'd1);
      @(posedge clk); #1;
      check_eq("ack_width", {31'd0, ready}, 32'd0);
    end

    // one-shot
    reg_write(8'h04, 3); reg_write(8'h08, 3); reg_write(8'h0C, 0); reg_write(8'h00, 5);
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      check_eq("oneshot_irq", {31'd0, irq}, {31'd0, k == 4});
    end
    reg_read(8'h00, q); check_eq("oneshot_ctrl", q, 32'h4);
    reg_read(8'h08, q); check_eq("oneshot_count", q, 32'h0);
    check_eq("irq_held", {31'd0, irq}, 32'd1);
    reg_write(8'h10, 1);
    check_eq("irq_w1c_fall", {31'd0, irq}, 32'd0);

    // auto-reload period and W1C/expiry collision
    reg_write(8'h00, 0); reg_write(8'h10, 1);
    reg_write(8'h04, 4); reg_write(8'h08, 4); reg_write(8'h0C, 1); reg_write(8'h00, 7);
    wait_irq(t0);
    reg_write(8'h10, 1);
    check_eq("ar_cleared", {31'd0, irq}, 32'd0);
    wait_irq(t1);
    check_eq("ar_period", 32'(t1 - t0), 32'd10);
    reg_write(8'h10, 1);
    check_eq("ar_cleared2", {31'd0, irq}, 32'd0);
    wait_cyc(t1 + 9);
    reg_write(8'h10, 1);
    reg_read(8'h10, q); check_eq("w1c_vs_expiry", q, 32'h1);

    // byte strobes, unmapped offset, out-of-window address
    reg_write(8'h00, 0);
    reg_write(8'h04, 32'h0);
    reg_write(8'h04, 32'hAABB_CCDD, 4'b0100);
    reg_read(8'h04, q); check_eq("strobe_load", q, 32'h00BB_0000);
    bus(BASE + 32'h40, 4'hF, 32'hFFFF_FFFF, q, ok, lat);
    check_eq("unmapped_ack", {31'd0, ok}, 32'd1);
    reg_read(8'h04, q); check_eq("unmapped_noeffect", q, 32'h00BB_0000);
    bus(32'h0400_0000, 4'h0, 32'h0, q, ok, lat);
    check_eq("oow_noack", {31'd0, ok}, 32'd0);
    check_eq("oow_rdata", q, 32'd0);

    // COUNT write on the expiring, reloading tick
    reg_write(8'h10, 1); reg_write(8'h0C, 3); reg_write(8'h04, 5); reg_write(8'h08, 0);
    reg_write(8'h00, 3);
    c = cyc;
    wait_cyc(c + 3);
    reg_write(8'h08, 100);
    reg_read(8'h08, q); check_eq("count_write_wins", q, 32'd100);
    reg_read(8'h10, q); check_eq("expired_on_collide", q, 32'h1);

`ifdef IOMEM_TIMER_PWM_EN
    reg_write(8'h00, 0); reg_write(8'h0C, 0); reg_write(8'h04, 9); reg_write(8'h08, 9);
    reg_write(8'h14, 3); reg_write(8'h00, 3);
    repeat (12) @(posedge clk);
    #1;
    n = 0;
    for (int k = 0; k < 10; k++) begin @(posedge clk); #1; n += int'(pwm); end
    check_eq("pwm_duty", 32'(n), 32'd3);
    n = 0;
    while (!pwm && n < 20) begin @(posedge clk); #1; n++; end
    check_eq("pwm_high_before_rst", {31'd0, pwm}, 32'd1);
    #2 reset = 1'b1;
    #1 check_eq("pwm_async_rst", {31'd0, pwm}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
`endif

    // randomized traffic from a fresh reset
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int it = 0; it < 250; it++) begin
      sel = $urandom_range(0, 9);
      if (sel <= 5)      a = BASE + 32'(sel * 4);
      else if (sel == 6) a = BASE + 32'($urandom_range(6, 63) * 4);
      else if (sel == 7) a = 32'h0400_0000 | 32'($urandom_range(0, 255));
      else               a = BASE + ((sel == 8) ? 32'h08 : 32'h10);
      d = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 12));
      if (sel == 0 && $urandom_range(0, 1) == 1) d[0] = 1'b1;
      if ($urandom_range(0, 1) == 0)      s = 4'h0;
      else if ($urandom_range(0, 1) == 0) s = 4'hF;
      else                                s = 4'($urandom_range(1, 15));
      bus(a, s, d, q, ok, lat);
      repeat ($urandom_range(0, 4)) begin @(posedge clk); #1; end
    end

    repeat (3) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
